stopwatch_core: RTL

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch core: 1 Hz counting in RUN, pause toggle on button edges,
// and a 2 Hz adjust mode that steps minutes or seconds with a blinking field.
module stopwatch_core #(
    parameter int TICK_DIV = 100000000,
    parameter int ADJ_DIV  = 50000000
) (
    input  logic       clk,
    input  logic       btnR,
    input  logic       pause_in,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       paused,
    output logic       blank_min,
    output logic       blank_sec
);

    localparam int D1W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int D2W = (ADJ_DIV > 1) ? $clog2(ADJ_DIV) : 1;
    localparam logic [D1W-1:0] DIV1_LAST = D1W'(TICK_DIV - 1);
    localparam logic [D2W-1:0] DIV2_LAST = D2W'(ADJ_DIV - 1);
    localparam logic [D1W-1:0] DIV1_ONE  = D1W'(1);
    localparam logic [D2W-1:0] DIV2_ONE  = D2W'(1);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    state_t         state_reg;
    logic           pause_prev_reg;
    logic           adj_prev_reg;
    logic [D1W-1:0] div1_reg;
    logic [D2W-1:0] div2_reg;
    logic           phase_reg;
    logic           blank_min_reg;
    logic           blank_sec_reg;
    logic [3:0]     min_tens_reg;
    logic [3:0]     min_ones_reg;
    logic [3:0]     sec_tens_reg;
    logic [3:0]     sec_ones_reg;

    logic           pause_edge;
    logic           adj_fall;
    logic           count_en;
    logic           tick1;
    logic           tick2;
    logic           sec_step;
    logic           min_step;
    logic           phase_next;
    logic [3:0]     min_tens_next;
    logic [3:0]     min_ones_next;
    logic [3:0]     sec_tens_next;
    logic [3:0]     sec_ones_next;

    assign pause_edge = pause_in & ~pause_prev_reg;
    assign adj_fall   = adj_prev_reg & ~adj;
    assign count_en   = (state_reg == ST_RUN) & ~adj;
    // The adjust-exit cycle restarts div1 instead of ticking, so the first
    // post-adjust second is always a full period.
    assign tick1      = count_en & ~adj_fall & (div1_reg == DIV1_LAST);
    assign tick2      = adj & (div2_reg == DIV2_LAST);
    assign phase_next = adj & (phase_reg ^ tick2);

    // In adjust mode each field wraps on its own; only counting carries seconds into minutes.
    assign sec_step = tick1 | (tick2 & sel);
    assign min_step = tick1 ? ((sec_ones_reg == 4'd9) & (sec_tens_reg == 4'd5))
                            : (tick2 & ~sel);

    always_comb begin
        sec_ones_next = sec_ones_reg;
        sec_tens_next = sec_tens_reg;
        min_ones_next = min_ones_reg;
        min_tens_next = min_tens_reg;
        if (sec_step) begin
            if (sec_ones_reg == 4'd9) begin
                sec_ones_next = 4'd0;
                sec_tens_next = (sec_tens_reg == 4'd5) ? 4'd0 : sec_tens_reg + 4'd1;
            end else begin
                sec_ones_next = sec_ones_reg + 4'd1;
            end
        end
        if (min_step) begin
            if (min_ones_reg == 4'd9) begin
                min_ones_next = 4'd0;
                min_tens_next = (min_tens_reg == 4'd5) ? 4'd0 : min_tens_reg + 4'd1;
            end else begin
                min_ones_next = min_ones_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (btnR) begin
            state_reg      <= ST_RUN;
            pause_prev_reg <= 1'b0;
            adj_prev_reg   <= 1'b0;
            div1_reg       <= '0;
            div2_reg       <= '0;
            phase_reg      <= 1'b0;
            blank_min_reg  <= 1'b0;
            blank_sec_reg  <= 1'b0;
            min_tens_reg   <= 4'd0;
            min_ones_reg   <= 4'd0;
            sec_tens_reg   <= 4'd0;
            sec_ones_reg   <= 4'd0;
        end else begin
            pause_prev_reg <= pause_in;
            adj_prev_reg   <= adj;
            if (pause_edge) begin
                state_reg <= (state_reg == ST_RUN) ? ST_PAUSED : ST_RUN;
            end

            if (adj_fall) begin
                div1_reg <= '0;
            end else if (count_en) begin
                div1_reg <= tick1 ? '0 : div1_reg + DIV1_ONE;
            end

            if (!adj || tick2) begin
                div2_reg <= '0;
            end else begin
                div2_reg <= div2_reg + DIV2_ONE;
            end

            phase_reg     <= phase_next;
            blank_min_reg <= adj & ~sel & phase_next;
            blank_sec_reg <= adj & sel & phase_next;

            min_tens_reg <= min_tens_next;
            min_ones_reg <= min_ones_next;
            sec_tens_reg <= sec_tens_next;
            sec_ones_reg <= sec_ones_next;
        end
    end

    assign min_tens  = min_tens_reg;
    assign min_ones  = min_ones_reg;
    assign sec_tens  = sec_tens_reg;
    assign sec_ones  = sec_ones_reg;
    assign paused    = (state_reg == ST_PAUSED);
    assign blank_min = blank_min_reg;
    assign blank_sec = blank_sec_reg;

endmodule
